// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of a single-master SDRAM controller port.
// One transaction in flight, round-robin on ties, req/ack/done per port,
// and a bounded wait for read data so a lost read cannot hang a requester.
module sdram_port_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  // requester port 0 (store / record path)
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_ack0,
  output logic              o_done0,
  output logic              o_err0,
  output logic [DATA_W-1:0] o_rdata0,
  // requester port 1 (load / playback path)
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack1,
  output logic              o_done1,
  output logic              o_err1,
  output logic [DATA_W-1:0] o_rdata1,
  // SDRAM controller side
  input  logic [DATA_W-1:0] i_SDRAM_DATA,
  input  logic              i_SDRAM_VALID,
  output logic              o_SDRAM_WRITE,
  output logic              o_SDRAM_READ,
  output logic [ADDR_W-1:0] o_SDRAM_ADDR,
  output logic [DATA_W-1:0] o_SDRAM_DQ,
  // status
  output logic              o_busy,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_READ   = 2'd2,
    S_UNUSED = 2'd3
  } state_t;

  // Counter must be able to hold TIMEOUT-1; TIMEOUT >= 1 keeps this non-negative.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_grant;
  logic              r_port;
  logic              r_busy;
  logic              r_ack0, r_ack1;
  logic              r_done0, r_done1;
  logic              r_err0, r_err1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;
  logic              r_sdram_write, r_sdram_read;
  logic [ADDR_W-1:0] r_sdram_addr;
  logic [DATA_W-1:0] r_sdram_dq;

  logic              w_any_req;
  logic              w_grant_port;
  logic              w_grant_we;
  logic [ADDR_W-1:0] w_grant_addr;
  logic [DATA_W-1:0] w_grant_data;

  // Arbitration choice: a lone request wins outright, a tie goes to the
  // port that did not win last time.
  always_comb begin
    w_any_req    = i_req0 | i_req1;
    w_grant_port = (i_req0 && i_req1) ? ~r_last_grant : i_req1;
    w_grant_we   = w_grant_port ? i_we1    : i_we0;
    w_grant_addr = w_grant_port ? i_addr1  : i_addr0;
    w_grant_data = w_grant_port ? i_wdata1 : i_wdata0;
  end

  // Main FSM: arbitration, strobe generation, read capture and timeout.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_last_grant  <= 1'b1;   // so port 0 wins the first tie
      r_port        <= 1'b0;
      r_busy        <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
      r_err0        <= 1'b0;
      r_err1        <= 1'b0;
      r_rdata0      <= '0;
      r_rdata1      <= '0;
      r_sdram_write <= 1'b0;
      r_sdram_read  <= 1'b0;
      r_sdram_addr  <= '0;
      r_sdram_dq    <= '0;
    end else begin
      // Pulse outputs default low; each branch raises only what it needs.
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
      r_err0        <= 1'b0;
      r_err1        <= 1'b0;
      r_sdram_write <= 1'b0;
      r_sdram_read  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_port       <= w_grant_port;
            r_last_grant <= w_grant_port;
            r_sdram_addr <= w_grant_addr;
            r_sdram_dq   <= w_grant_data;
            r_ack0       <= ~w_grant_port;
            r_ack1       <= w_grant_port;
            r_busy       <= 1'b1;
            if (w_grant_we) begin
              r_state       <= S_WRITE;
              r_sdram_write <= 1'b1;
            end else begin
              r_state      <= S_READ;
              r_sdram_read <= 1'b1;
              r_cnt        <= '0;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end

        // The write strobe cycle is the whole write; complete right away.
        S_WRITE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done0 <= ~r_port;
          r_done1 <= r_port;
        end

        // Wait for read data; valid on the last counted cycle still wins.
        S_READ: begin
          if (i_SDRAM_VALID) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done0 <= ~r_port;
            r_done1 <= r_port;
            if (r_port) r_rdata1 <= i_SDRAM_DATA;
            else        r_rdata0 <= i_SDRAM_DATA;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done0 <= ~r_port;
            r_done1 <= r_port;
            r_err0  <= ~r_port;
            r_err1  <= r_port;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack0        = r_ack0;
  assign o_ack1        = r_ack1;
  assign o_done0       = r_done0;
  assign o_done1       = r_done1;
  assign o_err0        = r_err0;
  assign o_err1        = r_err1;
  assign o_rdata0      = r_rdata0;
  assign o_rdata1      = r_rdata1;
  assign o_SDRAM_WRITE = r_sdram_write;
  assign o_SDRAM_READ  = r_sdram_read;
  assign o_SDRAM_ADDR  = r_sdram_addr;
  assign o_SDRAM_DQ    = r_sdram_dq;
  assign o_busy        = r_busy;
  assign o_state       = r_state;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scenario bench for sdram_port_arbiter: expected grants and completions are
// queued when stimulus is driven and popped when the DUT produces them.
module tb_sdram_port_arbiter;

  localparam int AW = 26;
  localparam int DW = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, done0, done1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic [DW-1:0] sd_data;
  logic          sd_valid;
  logic          sd_write, sd_read;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_dq;
  logic          busy;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } grant_t;

  typedef struct {
    int            port;
    bit            err;
    logic [DW-1:0] rdata;   // expected rdata of that port after done
  } done_t;

  grant_t        gq[$];
  done_t         dq[$];
  logic [DW-1:0] exp_rdata[2];

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_ack0(ack0), .o_done0(done0), .o_err0(err0), .o_rdata0(rdata0),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_ack1(ack1), .o_done1(done1), .o_err1(err1), .o_rdata1(rdata1),
    .i_SDRAM_DATA(sd_data), .i_SDRAM_VALID(sd_valid),
    .o_SDRAM_WRITE(sd_write), .o_SDRAM_READ(sd_read),
    .o_SDRAM_ADDR(sd_addr), .o_SDRAM_DQ(sd_dq),
    .o_busy(busy), .o_state(state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [127:0] got;
    rst_n = 1'b0;
    tick();
    tick();
    got = {ack0, ack1, done0, done1, err0, err1, rdata0, rdata1,
           sd_write, sd_read, sd_addr, sd_dq, busy, state};
    checks++;
    if (got !== 128'd0) begin
      errors++;
      $display("FAIL reset_outputs: actual %h required 0", got);
    end
    rst_n = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    tick();
  endtask

  // TP1: single write from port 0
  task automatic test_write();
    grant_t g;
    done_t d;
    logic [127:0] got, expv;
    req0 = 1; we0 = 1; addr0 = 26'h10; wdata0 = 16'hBEEF;
    gq.push_back('{0, 1'b1, 26'h10, 16'hBEEF});
    dq.push_back('{0, 1'b0, exp_rdata[0]});
    tick();
    req0 = 0; addr0 = '0; wdata0 = '0;
    g = gq.pop_front();
    got  = {ack1, ack0, sd_write, sd_read, sd_addr, sd_dq, busy, state};
    expv = {g.port == 1, g.port == 0, g.we, !g.we, g.addr, g.data, 1'b1,
            g.we ? 2'd1 : 2'd2};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL write_grant: actual %h required %h", got, expv);
    end
    tick();
    d = dq.pop_front();
    exp_rdata[d.port] = d.rdata;
    got  = {done1, done0, err1, err0, rdata0, rdata1, busy, state};
    expv = {d.port == 1, d.port == 0, d.err && d.port == 1, d.err && d.port == 0,
            exp_rdata[0], exp_rdata[1], 1'b0, 2'd0};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL write_done: actual %h required %h", got, expv);
    end
  endtask

  // TP3: both ports hammer writes from reset; grants must alternate 0,1,0,1
  task automatic test_round_robin();
    grant_t g;
    done_t d;
    logic [127:0] got, expv;
    rst_n = 0;
    tick();
    rst_n = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    req0 = 1; we0 = 1; addr0 = 26'h100; wdata0 = 16'hA000;
    req1 = 1; we1 = 1; addr1 = 26'h200; wdata1 = 16'hB001;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        gq.push_back('{0, 1'b1, 26'h100, 16'hA000});
        dq.push_back('{0, 1'b0, exp_rdata[0]});
      end else begin
        gq.push_back('{1, 1'b1, 26'h200, 16'hB001});
        dq.push_back('{1, 1'b0, exp_rdata[1]});
      end
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if ((ack0 && ack1) || (done0 && done1) || (err0 && err1)) begin
        errors++;
        $display("FAIL rr_exclusive: cycle %0d actual ack=%b%b done=%b%b required one-hot",
                 i, ack1, ack0, done1, done0);
      end
      if (i % 2 == 1) begin
        g = gq.pop_front();
        got  = {ack1, ack0, sd_write, sd_read, sd_addr, sd_dq, busy, state};
        expv = {g.port == 1, g.port == 0, g.we, !g.we, g.addr, g.data, 1'b1,
                g.we ? 2'd1 : 2'd2};
        checks++;
        if (got !== expv) begin
          errors++;
          $display("FAIL rr_grant: cycle %0d actual %h required %h", i, got, expv);
        end
      end else begin
        d = dq.pop_front();
        exp_rdata[d.port] = d.rdata;
        got  = {done1, done0, err1, err0, rdata0, rdata1, busy, state};
        expv = {d.port == 1, d.port == 0, d.err && d.port == 1, d.err && d.port == 0,
                exp_rdata[0], exp_rdata[1], 1'b0, 2'd0};
        checks++;
        if (got !== expv) begin
          errors++;
          $display("FAIL rr_done: cycle %0d actual %h required %h", i, got, expv);
        end
      end
    end
    req0 = 0; req1 = 0;
    tick();
    checks++;
    if ({ack0, ack1, sd_write, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL rr_extra_grant: actual %b required 0000", {ack0, ack1, sd_write, busy});
    end
  endtask

  // TP2: port 1 read, valid arrives on the last counted cycle (still success)
  task automatic test_read_port1();
    grant_t g;
    done_t d;
    logic [127:0] got, expv;
    req1 = 1; we1 = 0; addr1 = 26'h3FFFFFF; wdata1 = 16'h0001;
    gq.push_back('{1, 1'b0, 26'h3FFFFFF, 16'h0001});
    tick();
    req1 = 0;
    g = gq.pop_front();
    got  = {ack1, ack0, sd_write, sd_read, sd_addr, sd_dq, busy, state};
    expv = {g.port == 1, g.port == 0, g.we, !g.we, g.addr, g.data, 1'b1,
            g.we ? 2'd1 : 2'd2};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL rd1_grant: actual %h required %h", got, expv);
    end
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if ({sd_read, done0, done1, busy, state} !== {3'b000, 1'b1, 2'd2}) begin
        errors++;
        $display("FAIL rd1_wait: cycle %0d actual %b required 000110", c,
                 {sd_read, done0, done1, busy, state});
      end
    end
    tick();
    sd_valid = 1; sd_data = 16'h1234;
    dq.push_back('{1, 1'b0, 16'h1234});
    tick();
    sd_valid = 0; sd_data = 16'hDEAD;
    d = dq.pop_front();
    if (!d.err) exp_rdata[d.port] = d.rdata;
    got  = {done1, done0, err1, err0, rdata0, rdata1, busy, state};
    expv = {d.port == 1, d.port == 0, d.err && d.port == 1, d.err && d.port == 0,
            exp_rdata[0], exp_rdata[1], 1'b0, 2'd0};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL rd1_done: actual %h required %h", got, expv);
    end
  endtask

  // Port 0 read with valid already present in the strobe cycle
  task automatic test_read_port0_early();
    grant_t g;
    done_t d;
    logic [127:0] got, expv;
    req0 = 1; we0 = 0; addr0 = 26'h0ABCDEF; wdata0 = 16'h0002;
    gq.push_back('{0, 1'b0, 26'h0ABCDEF, 16'h0002});
    tick();
    req0 = 0;
    g = gq.pop_front();
    got  = {ack1, ack0, sd_write, sd_read, sd_addr, sd_dq, busy, state};
    expv = {g.port == 1, g.port == 0, g.we, !g.we, g.addr, g.data, 1'b1,
            g.we ? 2'd1 : 2'd2};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL rd0_grant: actual %h required %h", got, expv);
    end
    sd_valid = 1; sd_data = 16'h5A5A;
    dq.push_back('{0, 1'b0, 16'h5A5A});
    tick();
    sd_valid = 0; sd_data = 16'hDEAD;
    d = dq.pop_front();
    if (!d.err) exp_rdata[d.port] = d.rdata;
    got  = {done1, done0, err1, err0, rdata0, rdata1, busy, state};
    expv = {d.port == 1, d.port == 0, d.err && d.port == 1, d.err && d.port == 0,
            exp_rdata[0], exp_rdata[1], 1'b0, 2'd0};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL rd0_done: actual %h required %h", got, expv);
    end
  endtask

  // TP4: read with no valid times out after TO cycles in S_READ
  task automatic test_timeout();
    grant_t g;
    done_t d;
    logic [127:0] got, expv;
    sd_data = 16'hDEAD;
    req0 = 1; we0 = 0; addr0 = 26'h55; wdata0 = 16'h0003;
    gq.push_back('{0, 1'b0, 26'h55, 16'h0003});
    dq.push_back('{0, 1'b1, exp_rdata[0]});
    tick();
    req0 = 0;
    g = gq.pop_front();
    got  = {ack1, ack0, sd_write, sd_read, sd_addr, sd_dq, busy, state};
    expv = {g.port == 1, g.port == 0, g.we, !g.we, g.addr, g.data, 1'b1,
            g.we ? 2'd1 : 2'd2};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL to_grant: actual %h required %h", got, expv);
    end
    for (int c = 1; c < TO; c++) begin
      tick();
      checks++;
      if ({done0, done1, sd_read, busy} !== 4'b0001) begin
        errors++;
        $display("FAIL to_wait: cycle %0d actual %b required 0001", c,
                 {done0, done1, sd_read, busy});
      end
    end
    tick();
    d = dq.pop_front();
    if (!d.err) exp_rdata[d.port] = d.rdata;
    got  = {done1, done0, err1, err0, rdata0, rdata1, busy, state};
    expv = {d.port == 1, d.port == 0, d.err && d.port == 1, d.err && d.port == 0,
            exp_rdata[0], exp_rdata[1], 1'b0, 2'd0};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL to_done: actual %h required %h", got, expv);
    end
    tick();
    checks++;
    if ({done0, err0, busy} !== 3'b000) begin
      errors++;
      $display("FAIL to_after: actual %b required 000", {done0, err0, busy});
    end
  endtask

  // TP5: valid outside S_READ is ignored (idle and during a write)
  task automatic test_valid_ignored();
    grant_t g;
    done_t d;
    logic [127:0] got, expv;
    sd_valid = 1; sd_data = 16'hFFFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({done0, done1, rdata0, rdata1} !== {2'b00, exp_rdata[0], exp_rdata[1]}) begin
        errors++;
        $display("FAIL vi_idle: actual %h required %h", {done0, done1, rdata0, rdata1},
                 {2'b00, exp_rdata[0], exp_rdata[1]});
      end
    end
    req1 = 1; we1 = 1; addr1 = 26'h7; wdata1 = 16'h0707;
    gq.push_back('{1, 1'b1, 26'h7, 16'h0707});
    dq.push_back('{1, 1'b0, exp_rdata[1]});
    tick();
    req1 = 0;
    g = gq.pop_front();
    got  = {ack1, ack0, sd_write, sd_read, sd_addr, sd_dq, busy, state};
    expv = {g.port == 1, g.port == 0, g.we, !g.we, g.addr, g.data, 1'b1,
            g.we ? 2'd1 : 2'd2};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL vi_grant: actual %h required %h", got, expv);
    end
    tick();
    sd_valid = 0;
    d = dq.pop_front();
    if (!d.err) exp_rdata[d.port] = d.rdata;
    got  = {done1, done0, err1, err0, rdata0, rdata1, busy, state};
    expv = {d.port == 1, d.port == 0, d.err && d.port == 1, d.err && d.port == 0,
            exp_rdata[0], exp_rdata[1], 1'b0, 2'd0};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL vi_done: actual %h required %h", got, expv);
    end
  endtask

  // TP6: reset during a pending read abandons it; next tie goes to port 0
  task automatic test_reset_midread();
    grant_t g;
    done_t d;
    logic [127:0] got, expv;
    req0 = 1; we0 = 0; addr0 = 26'h20; wdata0 = 16'h0004;
    gq.push_back('{0, 1'b0, 26'h20, 16'h0004});
    tick();
    req0 = 0;
    g = gq.pop_front();
    got  = {ack1, ack0, sd_write, sd_read, sd_addr, sd_dq, busy, state};
    expv = {g.port == 1, g.port == 0, g.we, !g.we, g.addr, g.data, 1'b1,
            g.we ? 2'd1 : 2'd2};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL rst_grant: actual %h required %h", got, expv);
    end
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    got = {ack0, ack1, done0, done1, err0, err1, rdata0, rdata1,
           sd_write, sd_read, sd_addr, sd_dq, busy, state};
    checks++;
    if (got !== 128'd0) begin
      errors++;
      $display("FAIL rst_midread_outputs: actual %h required 0", got);
    end
    sd_valid = 1; sd_data = 16'h9999;
    for (int c = 0; c < 3; c++) begin
      tick();
      sd_valid = 0;
      checks++;
      if ({done0, done1, err0, err1, rdata0, busy, state} !== '0) begin
        errors++;
        $display("FAIL rst_no_done: cycle %0d actual %h required 0", c,
                 {done0, done1, err0, err1, rdata0, busy, state});
      end
    end
    req0 = 1; we0 = 1; addr0 = 26'h31; wdata0 = 16'hC0DE;
    req1 = 1; we1 = 1; addr1 = 26'h32; wdata1 = 16'hD00D;
    gq.push_back('{0, 1'b1, 26'h31, 16'hC0DE});
    dq.push_back('{0, 1'b0, exp_rdata[0]});
    tick();
    req0 = 0; req1 = 0;
    g = gq.pop_front();
    got  = {ack1, ack0, sd_write, sd_read, sd_addr, sd_dq, busy, state};
    expv = {g.port == 1, g.port == 0, g.we, !g.we, g.addr, g.data, 1'b1,
            g.we ? 2'd1 : 2'd2};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL rst_tie_grant: actual %h required %h", got, expv);
    end
    tick();
    d = dq.pop_front();
    if (!d.err) exp_rdata[d.port] = d.rdata;
    got  = {done1, done0, err1, err0, rdata0, rdata1, busy, state};
    expv = {d.port == 1, d.port == 0, d.err && d.port == 1, d.err && d.port == 0,
            exp_rdata[0], exp_rdata[1], 1'b0, 2'd0};
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL rst_tie_done: actual %h required %h", got, expv);
    end
  endtask

  initial begin
    rst_n = 0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    sd_valid = 0; sd_data = '0;
    test_reset();
    test_write();
    test_round_robin();
    test_read_port1();
    test_read_port0_early();
    test_timeout();
    test_valid_ignored();
    test_reset_midread();
    checks++;
    if (gq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual %0d/%0d left required 0/0", gq.size(), dq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
